// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the 3x3 convolution datapath: latches geometry, gates input
// pixels, tracks window validity through the pipeline and generates tlast/done.
module conv_frame_sequencer #(
  parameter int COL_BITS = 10,
  parameter int ROW_BITS = 10,
  parameter int PIPE_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [COL_BITS-1:0] cfg_width,
  input  logic [ROW_BITS-1:0] cfg_height,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                m_tready,
  output logic                m_tvalid,
  output logic                m_tlast,
  output logic                ce,
  output logic                lb_wr_en,
  output logic [COL_BITS-1:0] col_idx,
  output logic [ROW_BITS-1:0] row_idx,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int PW = COL_BITS + ROW_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [COL_BITS-1:0] w_r;
  logic [ROW_BITS-1:0] h_r;
  logic [COL_BITS-1:0] col_r;
  logic [ROW_BITS-1:0] row_r;
  logic [PW-1:0]       total_r;
  logic [PW-1:0]       out_cnt_r;
  logic [PIPE_LAT-1:0] vld_sr_r;
  logic                cfg_err_r;

  logic                geom_ok_s;
  logic                start_ok_s;
  logic                start_bad_s;
  logic                accept_s;
  logic                win_v_s;
  logic                col_last_s;
  logic                row_last_s;
  logic                out_hs_s;
  logic                last_hs_s;
  logic [PW-1:0]       total_s;

  // Output stall freezes the whole pipeline, including input acceptance.
  assign m_tvalid = vld_sr_r[PIPE_LAT-1];
  assign ce       = !(m_tvalid && !m_tready);
  assign s_tready = (state_r == RUN) && ce;
  assign accept_s = s_tvalid && s_tready;
  assign lb_wr_en = accept_s;
  assign col_idx  = col_r;
  assign row_idx  = row_r;
  assign cfg_err  = cfg_err_r;

  assign geom_ok_s   = (cfg_width >= COL_BITS'(3)) && (cfg_height >= ROW_BITS'(3));
  assign start_ok_s  = (state_r == IDLE) && start && geom_ok_s;
  assign start_bad_s = (state_r == IDLE) && start && !geom_ok_s;
  assign total_s     = PW'(cfg_width - COL_BITS'(2)) * PW'(cfg_height - ROW_BITS'(2));

  // A window is complete only once two full rows and two columns have been seen.
  assign win_v_s    = accept_s && (col_r >= COL_BITS'(2)) && (row_r >= ROW_BITS'(2));
  assign col_last_s = (col_r == w_r - COL_BITS'(1));
  assign row_last_s = (row_r == h_r - ROW_BITS'(1));
  assign out_hs_s   = m_tvalid && m_tready;
  assign m_tlast    = m_tvalid && (out_cnt_r == total_r - PW'(1));
  assign last_hs_s  = m_tlast && m_tready;

  // Next-state and status decode
  always_comb begin
    state_nxt_s = state_r;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = RUN;
        end else if (start_bad_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (accept_s && col_last_s && row_last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_hs_s || (vld_sr_r == {PIPE_LAT{1'b0}})) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE: begin
        done        = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, configuration, counters and validity pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      w_r       <= {COL_BITS{1'b0}};
      h_r       <= {ROW_BITS{1'b0}};
      col_r     <= {COL_BITS{1'b0}};
      row_r     <= {ROW_BITS{1'b0}};
      total_r   <= {PW{1'b0}};
      out_cnt_r <= {PW{1'b0}};
      vld_sr_r  <= {PIPE_LAT{1'b0}};
      cfg_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;

      if (start_ok_s) begin
        w_r       <= cfg_width;
        h_r       <= cfg_height;
        total_r   <= total_s;
        col_r     <= {COL_BITS{1'b0}};
        row_r     <= {ROW_BITS{1'b0}};
        out_cnt_r <= {PW{1'b0}};
        cfg_err_r <= 1'b0;
      end else begin
        if (start_bad_s) begin
          cfg_err_r <= 1'b1;
        end else begin
          cfg_err_r <= cfg_err_r;
        end
        if (accept_s) begin
          if (col_last_s) begin
            col_r <= {COL_BITS{1'b0}};
            row_r <= row_r + ROW_BITS'(1);
          end else begin
            col_r <= col_r + COL_BITS'(1);
          end
        end else begin
          col_r <= col_r;
        end
        if (out_hs_s) begin
          out_cnt_r <= out_cnt_r + PW'(1);
        end else begin
          out_cnt_r <= out_cnt_r;
        end
      end

      if (ce) begin
        vld_sr_r <= (vld_sr_r << 1) | PIPE_LAT'(win_v_s);
      end else begin
        vld_sr_r <= vld_sr_r;
      end
    end
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Sequences one image frame through the 3x3 convolution datapath.
- Latches the frame geometry on a start pulse from the AXI-lite control block and gates input pixel acceptance.
- Drives the line-buffer and window controls, tracks window validity through the datapath pipeline, and applies output backpressure as a global pipeline stall.
- Generates the output tlast, which feeds back to the control block as its frame-complete signal.

Parameters:
- COL_BITS, 10, width of the column counter and cfg_width.
- ROW_BITS, 10, width of the row counter and cfg_height.
- PIPE_LAT, 4, cycles from window shift to the result at the datapath output (minimum 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle frame start; honoured only in IDLE.
- cfg_width  in  COL_BITS  image width in pixels; sampled on an accepted start.
- cfg_height  in  ROW_BITS  image height in pixels; sampled on an accepted start.
- s_tvalid  in  1  input pixel valid.
- s_tready  out  1  input pixel ready.
- m_tready  in  1  downstream ready.
- m_tvalid  out  1  output pixel valid (pipeline tail).
- m_tlast  out  1  last output pixel of the frame.
- ce  out  1  pipeline clock enable for the line buffers, window registers and MAC stages.
- lb_wr_en  out  1  line-buffer write / window shift; equals the input handshake.
- col_idx  out  COL_BITS  column of the pixel being accepted.
- row_idx  out  ROW_BITS  row of the pixel being accepted.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the frame completes.
- cfg_err  out  1  sticky; set when geometry is below 3x3, cleared by the next accepted start.

Behaviour:
- Reset values:
  - state = IDLE.
  - Counters = 0.
  - Valid shift register (vld_sr, PIPE_LAT bits) = 0.
  - Outputs s_tready, m_tvalid, m_tlast, lb_wr_en, busy, done, cfg_err = 0; ce = 1.
  - Reset mid-frame aborts immediately. No done pulse is produced and a partial frame is not resumed.
- Pipeline enable and handshakes:
  - ce = !(m_tvalid && !m_tready). This is purely combinational.
  - s_tready = (state==RUN) && ce.
  - accept = s_tvalid && s_tready; lb_wr_en = accept.
  - col_idx and row_idx equal the coordinates of the pixel presented while in RUN.
- Counters:
  - col increments on accept and wraps from W-1 to 0.
  - row increments on the col wrap.
  - All counters are reset to 0 on an accepted start.
- Window validity:
  - win_v = accept && col>=2 && row>=2. There is no padding; each frame produces (W-2)*(H-2) outputs.
  - When ce=1, vld_sr shifts: win_v enters at bit 0.
  - When ce=0, vld_sr holds.
  - m_tvalid = vld_sr[PIPE_LAT-1]. The output valid therefore appears PIPE_LAT ce-cycles after the accepting cycle.
- Output counting:
  - out_cnt increments on m_tvalid && m_tready.
  - m_tlast = m_tvalid && (out_cnt == (W-2)*(H-2)-1).
  - The product is computed in COL_BITS+ROW_BITS bits and registered at start.
- State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE:
    - On start with W>=3 and H>=3: latch config, clear cfg_err, go to RUN.
    - On start with W<3 or H<3: set cfg_err, go to DONE without accepting any input.
  - RUN: on accepting the final pixel (col==W-1 && row==H-1), go to DRAIN.
  - DRAIN:
    - s_tready = 0.
    - Go to DONE in the cycle after the final output handshake (tlast && m_tready), or when vld_sr is all zeros.
  - DONE: done = 1 for one cycle, then go to IDLE.
- Boundary cases:
  - start while busy is ignored; config and counters are unchanged.
  - Simultaneous accept and stall cannot occur, because s_tready already includes ce.
  - m_tready low holds m_tvalid, m_tlast and vld_sr stable, and blocks new input.
  - W=3, H=3 produces exactly one output, with m_tlast set on it.
  - Maximum geometry (2^COL_BITS-1) wraps correctly with no counter overflow.

Test Plan:
- W=5, H=4, PIPE_LAT=4, s_tvalid and m_tready held high, start pulse:
  - Exactly 20 input handshakes and 6 outputs.
  - The first m_tvalid appears 4 cycles after the accept with col=2, row=2.
  - m_tlast on output 6, then done the cycle after; busy is low afterwards.
- Same frame, m_tready toggled 0/1 every cycle:
  - m_tvalid and m_tlast are stable while stalled, and s_tready=0 whenever ce=0.
  - Still 6 outputs, with tlast only on the last.
- W=3, H=3, s_tvalid random at 50%: 9 accepts, 1 output with m_tlast=1, one done pulse.
- start with W=2, H=8: cfg_err=1, done pulses within 2 cycles, zero input handshakes; the next valid start clears cfg_err.
- start asserted again mid-RUN with a different cfg_width: ignored, and the frame completes with the original geometry.
- rst asserted mid-RUN with 3 outputs in flight:
  - The next cycle has all outputs at reset values and vld_sr cleared.
  - A new start then runs a full 5x4 frame producing 6 outputs.
